// File: rtl/x_trim_cfg_sched.sv
// Frame-boundary configuration scheduler for x_trim: validates host config requests and commits
// them to the aclk_* config outputs only between frames. Optional stats: X_TRIM_CFG_SCHED_STATS_EN.
module x_trim_cfg_sched #(
  parameter int unsigned X_W        = 13,
  parameter int unsigned MAX_X_SIZE = 4096,
  parameter int unsigned MAX_SCALE  = 15
) (
  input  logic           aclk,
  input  logic           aclk_reset,
  input  logic [2:0]     host_pixel_width,
  input  logic           host_x_crop_en,
  input  logic [X_W-1:0] host_x_start,
  input  logic [X_W-1:0] host_x_size,
  input  logic [3:0]     host_x_scale,
  input  logic           host_x_reverse,
  input  logic           host_update_req,
  output logic           host_busy,
  output logic           host_done,
  output logic           host_cfg_error,
  input  logic           snoop_tvalid,
  input  logic           snoop_tready,
  input  logic [3:0]     snoop_tuser,
  output logic           in_frame,
`ifdef X_TRIM_CFG_SCHED_STATS_EN
  output logic [15:0]    stat_frame_cnt,
  output logic [7:0]     stat_drop_cnt,
`endif
  output logic [2:0]     aclk_pixel_width,
  output logic           aclk_x_crop_en,
  output logic [X_W-1:0] aclk_x_start,
  output logic [X_W-1:0] aclk_x_size,
  output logic [X_W-1:0] aclk_x_stop,
  output logic [3:0]     aclk_x_scale,
  output logic           aclk_x_reverse
);

  typedef struct packed {
    logic [2:0]     pixel_width;
    logic           crop_en;
    logic [X_W-1:0] x_start;
    logic [X_W-1:0] x_size;
    logic [3:0]     x_scale;
    logic           x_reverse;
  } cfg_t;

  typedef enum logic [1:0] {StIdle, StCheck, StWaitGap} state_e;

  localparam logic [X_W-1:0] ResetSize    = X_W'(MAX_X_SIZE);
  localparam logic [X_W-1:0] ResetStop    = X_W'(MAX_X_SIZE - 1);
  localparam logic [X_W:0]   MaxXSizeExt  = (X_W + 1)'(MAX_X_SIZE);
  localparam logic [4:0]     MaxScaleExt  = 5'(MAX_SCALE);

  localparam cfg_t ResetCfg = '{
    pixel_width: 3'd1,
    crop_en:     1'b0,
    x_start:     '0,
    x_size:      ResetSize,
    x_scale:     4'd0,
    x_reverse:   1'b0
  };

  state_e         state_q;
  cfg_t           shadow_q;
  cfg_t           active_q;
  logic [X_W-1:0] stop_q;
  logic           done_q;
  logic           err_q;
  logic           in_frame_q, in_frame_d;

  cfg_t           host_cfg;
  logic           beat;
  logic           sof_beat;
  logic           eof_beat;
  logic           gap_ok;
  logic           commit;
  logic           superseded;
  logic           shadow_legal;
  logic           pw_ok;
  logic [X_W:0]   roi_end;
  logic [X_W-1:0] shadow_stop;
  logic           unused_tuser;

  assign unused_tuser = ^snoop_tuser[3:2];

  assign host_cfg = '{
    pixel_width: host_pixel_width,
    crop_en:     host_x_crop_en,
    x_start:     host_x_start,
    x_size:      host_x_size,
    x_scale:     host_x_scale,
    x_reverse:   host_x_reverse
  };

  assign beat     = snoop_tvalid & snoop_tready;
  assign sof_beat = beat & snoop_tuser[0];
  assign eof_beat = beat & snoop_tuser[1];

  // A presented-but-unaccepted SOF already belongs to the next frame, so it blocks the commit.
  assign gap_ok     = ~in_frame_q & ~(snoop_tvalid & snoop_tuser[0]);
  assign commit     = (state_q == StWaitGap) & gap_ok;
  assign superseded = host_update_req & (state_q != StIdle) & ~commit;

  always_comb begin
    roi_end      = {1'b0, shadow_q.x_start} + {1'b0, shadow_q.x_size};
    pw_ok        = (shadow_q.pixel_width == 3'd1) || (shadow_q.pixel_width == 3'd2) ||
                   (shadow_q.pixel_width == 3'd4);
    shadow_legal = pw_ok && (shadow_q.x_size != '0) &&
                   ({1'b0, shadow_q.x_scale} <= MaxScaleExt) &&
                   (!shadow_q.crop_en || (roi_end <= MaxXSizeExt));
    shadow_stop  = shadow_q.x_start + shadow_q.x_size - X_W'(1);
  end

  always_comb begin
    in_frame_d = in_frame_q;
    if (eof_beat) begin
      in_frame_d = 1'b0;
    end else if (sof_beat) begin
      in_frame_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      in_frame_q <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state_q  <= StIdle;
      shadow_q <= ResetCfg;
      active_q <= ResetCfg;
      stop_q   <= ResetStop;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (host_update_req) begin
            shadow_q <= host_cfg;
            err_q    <= 1'b0;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          if (host_update_req) begin
            shadow_q <= host_cfg;
            err_q    <= 1'b0;
          end else if (shadow_legal) begin
            state_q <= StWaitGap;
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StWaitGap: begin
          if (gap_ok) begin
            active_q <= shadow_q;
            stop_q   <= shadow_stop;
            done_q   <= 1'b1;
          end
          // A coincident request still lets the current commit finish.
          if (host_update_req) begin
            shadow_q <= host_cfg;
            err_q    <= 1'b0;
            state_q  <= StCheck;
          end else if (gap_ok) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef X_TRIM_CFG_SCHED_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  drop_cnt_q;

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (eof_beat) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (superseded && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign stat_frame_cnt = frame_cnt_q;
  assign stat_drop_cnt  = drop_cnt_q;
`else
  logic unused_superseded;
  assign unused_superseded = superseded;
`endif

  assign host_busy        = (state_q != StIdle);
  assign host_done        = done_q;
  assign host_cfg_error   = err_q;
  assign in_frame         = in_frame_q;
  assign aclk_pixel_width = active_q.pixel_width;
  assign aclk_x_crop_en   = active_q.crop_en;
  assign aclk_x_start     = active_q.x_start;
  assign aclk_x_size      = active_q.x_size;
  assign aclk_x_stop      = stop_q;
  assign aclk_x_scale     = active_q.x_scale;
  assign aclk_x_reverse   = active_q.x_reverse;

endmodule

// File: tb/tb_x_trim_cfg_sched.sv
// Self-checking bench for x_trim_cfg_sched: transaction-level model compared every cycle,
// plus directed literal expectations.
module tb_x_trim_cfg_sched;

  logic        aclk = 1'b0;
  logic        aclk_reset;
  logic [2:0]  host_pixel_width;
  logic        host_x_crop_en;
  logic [12:0] host_x_start;
  logic [12:0] host_x_size;
  logic [3:0]  host_x_scale;
  logic        host_x_reverse;
  logic        host_update_req;
  logic        host_busy;
  logic        host_done;
  logic        host_cfg_error;
  logic        snoop_tvalid;
  logic        snoop_tready;
  logic [3:0]  snoop_tuser;
  logic        in_frame;
  logic [2:0]  aclk_pixel_width;
  logic        aclk_x_crop_en;
  logic [12:0] aclk_x_start;
  logic [12:0] aclk_x_size;
  logic [12:0] aclk_x_stop;
  logic [3:0]  aclk_x_scale;
  logic        aclk_x_reverse;
`ifdef X_TRIM_CFG_SCHED_STATS_EN
  logic [15:0] stat_frame_cnt;
  logic [7:0]  stat_drop_cnt;
`endif

  always #5 aclk = ~aclk;

  x_trim_cfg_sched dut (
    .aclk             (aclk),
    .aclk_reset       (aclk_reset),
    .host_pixel_width (host_pixel_width),
    .host_x_crop_en   (host_x_crop_en),
    .host_x_start     (host_x_start),
    .host_x_size      (host_x_size),
    .host_x_scale     (host_x_scale),
    .host_x_reverse   (host_x_reverse),
    .host_update_req  (host_update_req),
    .host_busy        (host_busy),
    .host_done        (host_done),
    .host_cfg_error   (host_cfg_error),
    .snoop_tvalid     (snoop_tvalid),
    .snoop_tready     (snoop_tready),
    .snoop_tuser      (snoop_tuser),
    .in_frame         (in_frame),
`ifdef X_TRIM_CFG_SCHED_STATS_EN
    .stat_frame_cnt   (stat_frame_cnt),
    .stat_drop_cnt    (stat_drop_cnt),
`endif
    .aclk_pixel_width (aclk_pixel_width),
    .aclk_x_crop_en   (aclk_x_crop_en),
    .aclk_x_start     (aclk_x_start),
    .aclk_x_size      (aclk_x_size),
    .aclk_x_stop      (aclk_x_stop),
    .aclk_x_scale     (aclk_x_scale),
    .aclk_x_reverse   (aclk_x_reverse)
  );

  int errs = 0;
  int checks = 0;
  int chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: active config, one pending request with its age in cycles since capture.
  int m_pw, m_crop, m_start, m_size, m_scale, m_rev;
  int m_done, m_err, m_frame, m_fcnt, m_drop;
  int p_valid, p_age, p_legal;
  int p_pw, p_crop, p_start, p_size, p_scale, p_rev;
  int commit, dropped;

  function automatic int legal(input int pw, input int crop, input int start, input int size,
                               input int scale);
    return ((pw == 1 || pw == 2 || pw == 4) && size != 0 && scale <= 15 &&
            (crop == 0 || start + size <= 4096)) ? 1 : 0;
  endfunction

  always @(posedge aclk) begin
    if (aclk_reset) begin
      m_pw = 1; m_crop = 0; m_start = 0; m_size = 4096; m_scale = 0; m_rev = 0;
      m_done = 0; m_err = 0; m_frame = 0; m_fcnt = 0; m_drop = 0;
      p_valid = 0; p_age = 0; p_legal = 0;
    end else begin
      commit  = (p_valid == 1 && p_age == 1 && m_frame == 0 &&
                 !(snoop_tvalid && snoop_tuser[0])) ? 1 : 0;
      dropped = (host_update_req && p_valid == 1 && commit == 0) ? 1 : 0;
      m_done  = commit;
      if (commit == 1) begin
        m_pw = p_pw; m_crop = p_crop; m_start = p_start; m_size = p_size;
        m_scale = p_scale; m_rev = p_rev;
        p_valid = 0;
      end else if (p_valid == 1 && p_age == 0) begin
        if (p_legal == 1) begin
          p_age = 1;
        end else begin
          p_valid = 0;
          m_err = 1;
        end
      end
      if (host_update_req) begin
        p_valid = 1; p_age = 0; m_err = 0;
        p_pw = int'(host_pixel_width); p_crop = int'(host_x_crop_en);
        p_start = int'(host_x_start); p_size = int'(host_x_size);
        p_scale = int'(host_x_scale); p_rev = int'(host_x_reverse);
        p_legal = legal(p_pw, p_crop, p_start, p_size, p_scale);
      end
      if (dropped == 1 && m_drop < 255) m_drop++;
      if (snoop_tvalid && snoop_tready) begin
        if (snoop_tuser[1]) begin
          m_frame = 0;
          m_fcnt = (m_fcnt + 1) & 65535;
        end else if (snoop_tuser[0]) begin
          m_frame = 1;
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (chk_en == 1) begin
      chk("busy", 32'(host_busy), p_valid);
      chk("done", 32'(host_done), m_done);
      chk("cfg_error", 32'(host_cfg_error), m_err);
      chk("in_frame", 32'(in_frame), m_frame);
      chk("pixel_width", 32'(aclk_pixel_width), m_pw);
      chk("crop_en", 32'(aclk_x_crop_en), m_crop);
      chk("x_start", 32'(aclk_x_start), m_start);
      chk("x_size", 32'(aclk_x_size), m_size);
      chk("x_stop", 32'(aclk_x_stop), (m_start + m_size - 1) & 8191);
      chk("x_scale", 32'(aclk_x_scale), m_scale);
      chk("x_reverse", 32'(aclk_x_reverse), m_rev);
`ifdef X_TRIM_CFG_SCHED_STATS_EN
      chk("frame_cnt", 32'(stat_frame_cnt), m_fcnt);
      chk("drop_cnt", 32'(stat_drop_cnt), m_drop);
`endif
    end
  end

  task automatic cycle();
    @(posedge aclk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic req(input int pw, input int crop, input int start, input int size,
                     input int scale, input int rev);
    host_pixel_width = 3'(pw);
    host_x_crop_en   = 1'(crop);
    host_x_start     = 13'(start);
    host_x_size      = 13'(size);
    host_x_scale     = 4'(scale);
    host_x_reverse   = 1'(rev);
    host_update_req  = 1'b1;
    cycle();
    host_update_req  = 1'b0;
  endtask

  task automatic beat(input int user);
    snoop_tvalid = 1'b1;
    snoop_tready = 1'b1;
    snoop_tuser  = 4'(user);
    cycle();
    snoop_tvalid = 1'b0;
    snoop_tready = 1'b0;
    snoop_tuser  = 4'd0;
  endtask

  initial begin
    int bad_pw[3];
    int bad_crop[3];
    int bad_start[3];
    int bad_size[3];
    bad_pw    = '{3, 1, 1};
    bad_crop  = '{0, 1, 0};
    bad_start = '{0, 4000, 0};
    bad_size  = '{64, 200, 0};

    aclk_reset = 1'b1;
    host_pixel_width = 3'd0; host_x_crop_en = 1'b0; host_x_start = '0; host_x_size = '0;
    host_x_scale = 4'd0; host_x_reverse = 1'b0; host_update_req = 1'b0;
    snoop_tvalid = 1'b0; snoop_tready = 1'b0; snoop_tuser = 4'd0;
    cycle();
    chk_en = 1;
    cycle();
    aclk_reset = 1'b0;

    // Reset values
    chk("t1_start", 32'(aclk_x_start), 0);
    chk("t1_size", 32'(aclk_x_size), 4096);
    chk("t1_stop", 32'(aclk_x_stop), 4095);
    chk("t1_pw", 32'(aclk_pixel_width), 1);
    chk("t1_busy", 32'(host_busy), 0);

    // Idle stream: commit lands two edges after the request edge
    req(1, 1, 1, 128, 1, 1);
    chk("t2_busy", 32'(host_busy), 1);
    cycle();
    chk("t2_done_early", 32'(host_done), 0);
    cycle();
    chk("t2_done", 32'(host_done), 1);
    chk("t2_stop", 32'(aclk_x_stop), 128);
    cycle();
    chk("t2_done_once", 32'(host_done), 0);

    // Request inside a frame waits for the cycle after the EOF beat
    beat(1);
    chk("t3_in_frame", 32'(in_frame), 1);
    beat(0);
    req(2, 1, 8, 64, 0, 0);
    idle(5);
    chk("t3_busy", 32'(host_busy), 1);
    chk("t3_hold", 32'(aclk_x_start), 1);
    beat(2);
    chk("t3_hold_eof", 32'(aclk_x_start), 1);
    cycle();
    chk("t3_done", 32'(host_done), 1);
    chk("t3_stop", 32'(aclk_x_stop), 71);

    // SOF presented but not accepted blocks commit
    snoop_tvalid = 1'b1; snoop_tuser = 4'd1; snoop_tready = 1'b0;
    req(1, 0, 0, 4096, 0, 0);
    idle(4);
    chk("t3b_blocked", 32'(host_busy), 1);
    chk("t3b_pw_hold", 32'(aclk_pixel_width), 2);
    snoop_tready = 1'b1;
    cycle();
    snoop_tvalid = 1'b0; snoop_tready = 1'b0; snoop_tuser = 4'd0;
    chk("t3b_in_frame", 32'(in_frame), 1);
    beat(2);
    cycle();
    chk("t3b_done", 32'(host_done), 1);
    chk("t3b_pw", 32'(aclk_pixel_width), 1);

    // Single-beat frame leaves in_frame low
    beat(3);
    chk("sb_in_frame", 32'(in_frame), 0);

    // Illegal requests
    for (int i = 0; i < 3; i++) begin
      req(bad_pw[i], bad_crop[i], bad_start[i], bad_size[i], 2, 0);
      cycle();
      chk("t4_err", 32'(host_cfg_error), 1);
      chk("t4_busy", 32'(host_busy), 0);
      idle(2);
    end
    // ROI ending exactly at MAX_X_SIZE is legal; new request clears the error
    req(4, 1, 4000, 96, 15, 1);
    chk("t4_err_clr", 32'(host_cfg_error), 0);
    idle(2);
    chk("t4_edge_stop", 32'(aclk_x_stop), 4095);

    // Two requests one cycle apart during a frame
    aclk_reset = 1'b1;
    idle(2);
    aclk_reset = 1'b0;
    beat(1);
    req(4, 1, 0, 100, 0, 0);
    req(1, 1, 16, 32, 3, 0);
    idle(3);
    beat(2);
    cycle();
    chk("t5_done", 32'(host_done), 1);
    chk("t5_start", 32'(aclk_x_start), 16);
    chk("t5_scale", 32'(aclk_x_scale), 3);
`ifdef X_TRIM_CFG_SCHED_STATS_EN
    chk("t5_drop", 32'(stat_drop_cnt), 1);
    chk("t5_frames", 32'(stat_frame_cnt), 1);
`endif

    // Reset while waiting for the gap discards the pending request
    beat(1);
    req(2, 1, 100, 200, 4, 1);
    idle(3);
    aclk_reset = 1'b1;
    idle(2);
    aclk_reset = 1'b0;
    chk("t6_busy", 32'(host_busy), 0);
    chk("t6_size", 32'(aclk_x_size), 4096);
    chk("t6_in_frame", 32'(in_frame), 0);
    beat(2);
    idle(3);
    chk("t6_size_after", 32'(aclk_x_size), 4096);
    chk("t6_start_after", 32'(aclk_x_start), 0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
